// File: rtl/mips_regwrite_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mips_pkg : shared constants and state encoding for the write arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_pkg;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int GID_W    = 3;

  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  localparam logic CLEAR = 1'b0;
  localparam logic RUN   = 1'b1;
endpackage

`default_nettype wire

// File: rtl/mips_regwrite_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mips_regwrite_arbiter_if : requester bus and register-file write port |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mips_regwrite_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*REG_W-1:0]  req_reg;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [REG_W-1:0]          write_reg;
  logic [DATA_W-1:0]         write_data;
  logic                      sig_reg_write;
  logic [2:0]                grant_id;
  logic                      busy;

  modport master (
    output req_valid, req_reg, req_data,
    input  req_ready, write_reg, write_data, sig_reg_write, grant_id, busy
  );

  modport slave (
    input  req_valid, req_reg, req_data,
    output req_ready, write_reg, write_data, sig_reg_write, grant_id, busy
  );
endinterface

`default_nettype wire

// File: rtl/mips_regwrite_arbiter_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, search from ptr+1 upward |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 3
) (
  input  wire logic [NUM_REQ-1:0] req_i,
  input  wire logic [IDX_W-1:0]   ptr_i,
  output logic      [NUM_REQ-1:0] gnt_o,
  output logic      [IDX_W-1:0]   idx_o
);
  localparam int SEL_W = $clog2(NUM_REQ);

  always_comb begin
    int   cand;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[SEL_W'(cand)]) begin
        found               = 1'b1;
        gnt_o[SEL_W'(cand)] = 1'b1;
        idx_o               = IDX_W'(cand);
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/mips_regwrite_arbiter.sv
// +----------------------------------------------------------------------+
// | mips_regwrite_arbiter : round-robin sharing of the regfile write port |
// | Rev 1.0  Option: REGARB_CLEAR_EN (sweep regs 1..31 to zero on reset) |
// +----------------------------------------------------------------------+
`default_nettype none

module mips_regwrite_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32
) (
  input wire logic clk,
  input wire logic reset,
  mips_regwrite_arbiter_if.slave bus
);
  import mips_pkg::*;

  logic [NUM_REQ-1:0] w_gnt;
  logic [GID_W-1:0]   w_idx;
  logic               w_xfer;
  logic               w_run;
  logic               w_busy;
  logic [REG_W-1:0]   w_sweep_reg;
  logic [REG_W-1:0]   w_sel_reg;
  logic [DATA_W-1:0]  w_sel_data;

  logic [GID_W-1:0]   ptr_q;
  logic [REG_W-1:0]   wreg_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               we_q;
  logic [GID_W-1:0]   gid_q;

`ifdef REGARB_CLEAR_EN
  logic       state_q;
  logic       state_d;
  logic [4:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && cnt_q == 5'(NUM_REGS - 1)) state_d = RUN;
  end

  always_comb begin
    w_busy = (state_q == CLEAR);
    w_run  = ~w_busy;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt_q <= 5'd1;
    else if (state_q == CLEAR) cnt_q <= cnt_q + 5'd1;
  end

  assign w_sweep_reg = REG_W'(cnt_q);
`else
  assign w_busy      = 1'b0;
  assign w_run       = 1'b1;
  assign w_sweep_reg = '0;
`endif

  // Requests are masked while sweeping so nothing is consumed during CLEAR.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (GID_W)
  ) u_rr (
    .req_i (bus.req_valid & {NUM_REQ{w_run}}),
    .ptr_i (ptr_q),
    .gnt_o (w_gnt),
    .idx_o (w_idx)
  );

  assign w_xfer = |w_gnt;

  always_comb begin
    w_sel_reg  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_reg  = bus.req_reg[i*REG_W +: REG_W];
        w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= GID_W'(NUM_REQ - 1);
      wreg_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      gid_q   <= '0;
    end else if (!w_run) begin
      wreg_q  <= w_sweep_reg;
      wdata_q <= '0;
      we_q    <= 1'b1;
    end else if (w_xfer) begin
      // Register 0 writes are consumed but never reach the register file.
      wreg_q  <= w_sel_reg;
      wdata_q <= w_sel_data;
      we_q    <= (w_sel_reg != REG_W'(ZERO_REG));
      gid_q   <= w_idx;
      ptr_q   <= w_idx;
    end else begin
      we_q    <= 1'b0;
    end
  end

  assign bus.req_ready     = w_gnt;
  assign bus.write_reg     = wreg_q;
  assign bus.write_data    = wdata_q;
  assign bus.sig_reg_write = we_q;
  assign bus.grant_id      = gid_q;
  assign bus.busy          = w_busy;
endmodule

`default_nettype wire

// File: tb/tb_mips_regwrite_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mips_regwrite_arbiter : scoreboard bench with round-robin model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mips_regwrite_arbiter;
  localparam int N  = 3;
  localparam int RW = 5;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_regwrite_arbiter_if #(.NUM_REQ(N), .REG_W(RW), .DATA_W(DW)) bus ();

  mips_regwrite_arbiter #(.NUM_REQ(N), .REG_W(RW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic          we;
    logic [RW-1:0] r;
    logic [DW-1:0] d;
    logic [2:0]    g;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   bad    = 0;
  bit   mon_en = 1'b0;

  int            m_ptr;
  logic [RW-1:0] m_reg;
  logic [DW-1:0] m_data;
  logic [2:0]    m_gid;

  logic [N-1:0]  cur_v;
  logic [RW-1:0] cur_r[N];
  logic [DW-1:0] cur_d[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Reference: rotate the request vector so the slot after the last winner comes first.
  function automatic int model_winner(input logic [N-1:0] v, input int last);
    int order[$];
    for (int k = 1; k <= N; k++) order.push_back((last + k) % N);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic drive_inputs();
    logic [N*RW-1:0] fr;
    logic [N*DW-1:0] fd;
    for (int i = 0; i < N; i++) begin
      fr[i*RW +: RW] = cur_r[i];
      fd[i*DW +: DW] = cur_d[i];
    end
    bus.req_valid = cur_v;
    bus.req_reg   = fr;
    bus.req_data  = fd;
  endtask

  // Called right after a falling edge: presents inputs, checks ready, queues the next-cycle outputs.
  task automatic apply(output int win);
    logic [N-1:0] er;
    exp_t         e;
    drive_inputs();
    #1;
    chk("busy_run", 64'(bus.busy), 64'(0));
    win = model_winner(cur_v, m_ptr);
    er  = '0;
    if (win >= 0) er = N'(1) << win;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    e.we = 1'b0;
    if (win >= 0) begin
      m_ptr  = win;
      m_reg  = cur_r[win];
      m_data = cur_d[win];
      m_gid  = 3'(win);
      e.we   = (cur_r[win] != '0);
    end
    e.r = m_reg;
    e.d = m_data;
    e.g = m_gid;
    exp_q.push_back(e);
  endtask

  task automatic sweep(input int cnt);
    exp_t e;
    for (int k = 1; k <= cnt; k++) begin
      @(negedge clk);
      cur_v = N'($urandom);
      drive_inputs();
      #1;
      chk("clr_busy", 64'(bus.busy), 64'(1));
      chk("clr_ready", 64'(bus.req_ready), 64'(0));
      m_reg  = RW'(k);
      m_data = '0;
      e.we = 1'b1;
      e.r  = m_reg;
      e.d  = m_data;
      e.g  = m_gid;
      exp_q.push_back(e);
    end
    cur_v = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    mon_en = 1'b0;
    exp_q.delete();
    chk("rst_we",   64'(bus.sig_reg_write), 64'(0));
    chk("rst_reg",  64'(bus.write_reg),     64'(0));
    chk("rst_data", 64'(bus.write_data),    64'(0));
    chk("rst_gid",  64'(bus.grant_id),      64'(0));
`ifdef REGARB_CLEAR_EN
    chk("rst_busy", 64'(bus.busy), 64'(1));
`else
    chk("rst_busy", 64'(bus.busy), 64'(0));
`endif
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    m_ptr  = N - 1;
    m_reg  = '0;
    m_data = '0;
    m_gid  = '0;
    cur_v  = '0;
    mon_en = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sig_reg_write", 64'(bus.sig_reg_write), 64'(e.we));
        chk("write_reg",     64'(bus.write_reg),     64'(e.r));
        chk("write_data",    64'(bus.write_data),    64'(e.d));
        chk("grant_id",      64'(bus.grant_id),      64'(e.g));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int w;
    cur_v = '0;
    for (int i = 0; i < N; i++) begin
      cur_r[i] = '0;
      cur_d[i] = '0;
    end
    drive_inputs();

    do_reset();
`ifdef REGARB_CLEAR_EN
    sweep(31);
`endif

    // All three requesters continuously valid: rotating 0,1,2,0,1,2.
    for (int i = 0; i < N; i++) begin
      cur_r[i] = RW'(i + 1);
      cur_d[i] = 32'hAAAA0001 + DW'(i);
    end
    for (int rep = 0; rep < 6; rep++) begin
      cur_v = '1;
      @(negedge clk);
      apply(w);
    end

    // Single requester 2.
    cur_v    = 3'b100;
    cur_r[2] = 5'd5;
    cur_d[2] = 32'hDEADBEEF;
    @(negedge clk);
    apply(w);

    // Register 0 write: consumed without a write enable.
    cur_v    = 3'b001;
    cur_r[0] = 5'd0;
    cur_d[0] = 32'hFFFFFFFF;
    @(negedge clk);
    apply(w);

    // Pointer now at 0, so requester 1 must win next.
    cur_r[0] = 5'd7;
    cur_v    = 3'b111;
    @(negedge clk);
    apply(w);

    // Idle: outputs hold, write enable drops.
    cur_v = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      apply(w);
    end

`ifdef REGARB_CLEAR_EN
    do_reset();
    sweep(9);
    do_reset();
    sweep(31);
`else
    cur_v = 3'b110;
    @(negedge clk);
    apply(w);
    do_reset();
`endif

    // Randomized traffic obeying the hold-until-transfer rule.
    cur_v = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!cur_v[i]) begin
          cur_v[i] = ($urandom_range(0, 2) != 0);
          cur_r[i] = RW'($urandom);
          cur_d[i] = $urandom;
        end
      end
      @(negedge clk);
      apply(w);
      if (w >= 0) cur_v[w] = 1'b0;
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drain", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/mips_regwrite_arbiter.md
Name: mips_regwrite_arbiter

Overview:
- Shares the single write port of mips_registers (write_reg, write_data, sig_reg_write) among NUM_REQ writeback requesters, e.g. ALU result, load data and debug/loader.
- Arbitration is round-robin with a valid/ready handshake per requester; outputs are registered.
- Optionally sweeps registers 1..31 to zero after reset before accepting requests.
- Sits between the writeback sources and the register file; read ports are untouched.

Parameters:
- NUM_REQ, 3, number of write requesters (2..8)
- REG_W, 5, register address width
- DATA_W, 32, write data width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester write request
- req_reg  in  NUM_REQ*REG_W  flattened destination addresses; requester i at [i*REG_W +: REG_W]
- req_data  in  NUM_REQ*DATA_W  flattened write data; requester i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid&ready on a rising edge
- write_reg  out  REG_W  to register file write address
- write_data  out  DATA_W  to register file write data
- sig_reg_write  out  1  to register file write enable
- grant_id  out  3  index of the requester whose write is on the outputs
- busy  out  1  high while in CLEAR state

Behaviour:
- Reset values (asynchronous):
  - write_reg=0, write_data=0, sig_reg_write=0, grant_id=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Sweep counter = 1.
  - State = CLEAR if REGARB_CLEAR_EN is defined, else RUN.
- State CLEAR:
  - busy=1; req_ready=0.
  - Each cycle drives write_reg=counter, write_data=0, sig_reg_write=1, then counter+1.
  - After counter==31 is issued, go to RUN; 31 cycles total, register 0 is never written.
- State RUN:
  - busy=0.
  - req_ready is combinational from req_valid and the pointer. The winner is the first valid requester searching from pointer+1 upward, with modulo NUM_REQ wrap.
  - At most one bit of req_ready is high; req_ready=0 when no request is valid.
- On a transfer at edge N:
  - Outputs load write_reg=req_reg[w], write_data=req_data[w], grant_id=w and sig_reg_write=1, and hold stable for cycle N+1. Latency is 1 cycle.
  - pointer<=w.
  - With no transfer at edge N, sig_reg_write<=0; write_reg, write_data and grant_id hold their values.
- Writes to register 0 are granted and consumed (ready asserted, pointer advances) but sig_reg_write<=0.
- Requesters hold req_reg and req_data stable while valid and not ready; a requester may deassert valid only after its transfer. The arbiter does not check this.
- Back-to-back:
  - Continuously asserting requesters are served one per cycle in rotating order; no requester waits more than NUM_REQ-1 grants.
  - A single requester held valid gets a grant every cycle.
- Reset mid-operation (during CLEAR or RUN) immediately returns to reset values; the CLEAR sweep restarts from register 1 after reset deasserts.
- An in-flight registered write is lost on reset.
- No data storage beyond the one output stage; no FIFO.

Optional Feature:
- REGARB_CLEAR_EN
- Defined: CLEAR state and 5-bit sweep counter are present; after reset, busy=1 for 31 cycles while 1..31 are written with zero, then RUN.
- Undefined: no CLEAR state or counter; busy is tied 0 and arbitration starts on the first edge after reset.

Decomposition:
- Shared package mips_pkg holds:
  - REG_W=5, DATA_W=32, NUM_REGS=32
  - ZERO_REG=5'd0
  - State encoding: CLEAR=1'b0, RUN=1'b1
- One natural sub-module: rr_arbiter. It is parameterized by NUM_REQ, takes req and pointer, and produces a one-hot grant plus the encoded index; it is purely combinational. The top holds the FSM, pointer, counter and output registers.

Test Plan:
- Reset, then release with REGARB_CLEAR_EN defined -> busy=1 for 31 cycles; write_reg walks 1..31 with write_data=0 and sig_reg_write=1; req_ready=0 throughout; then busy=0.
- req_valid=3'b111 continuously with reg 1/2/3 and data AAAA0001/AAAA0002/AAAA0003 -> grants repeat 0,1,2,0,1,2; each write appears the cycle after its grant with matching reg and data.
- Only requester 2 valid with reg 5, data DEADBEEF -> req_ready=3'b100 the same cycle; next cycle write_reg=5, write_data=DEADBEEF, sig_reg_write=1, grant_id=2.
- Requester 0 writes reg 0 with FFFFFFFF -> req_ready[0]=1 and pointer advances; sig_reg_write=0 next cycle.
- No requests for 3 cycles after a write -> sig_reg_write=0; write_reg and write_data hold their last values.
- Assert reset during CLEAR at counter=10, release -> all outputs 0 immediately; the sweep restarts at register 1 and takes a full 31 cycles.
